riscv_reg_file: RTL and testbench
=================================

// Module: riscv_reg_file
// PURPOSE
//   RV32I integer register file: 32 x 32-bit general-purpose registers (x0..x31).
//   Two asynchronous (combinational) read ports and one synchronous write port.
//   Sits in the core datapath; decode drives rs1/rs2/rd, writeback drives wr_data.
//   x0 is hardwired to zero: writes are discarded and reads always return 0.
// PARAMETERS
//   DATA_WIDTH  32  width of each register and of the data ports
//   NUM_REGS    32  number of architectural registers, including x0
//   ADDR_WIDTH  5   register index width; must equal $clog2(NUM_REGS)
// PORTS
//   clk        in   1           clock; all state updates occur on the rising edge
//   rst_n      in   1           asynchronous, active-low reset
//   wr_en      in   1           write enable
//   wr_reg     in   ADDR_WIDTH  destination register index (rd)
//   wr_data    in   DATA_WIDTH  write data
//   rd_reg_1   in   ADDR_WIDTH  read port 1 index (rs1)
//   rd_reg_2   in   ADDR_WIDTH  read port 2 index (rs2)
//   rd_data_1  out  DATA_WIDTH  read port 1 data
//   rd_data_2  out  DATA_WIDTH  read port 2 data
// BEHAVIOUR
//   - Reset: on rst_n falling, asynchronously clear all registers x1..x31 to 0.
//     Reset state is held while rst_n=0; writes are ignored during reset.
//     Read outputs reflect the cleared state combinationally (0).
//   - Write: at posedge clk, if rst_n=1 && wr_en=1 && wr_reg!=0, then reg[wr_reg] <= wr_data.
//     wr_en=0 leaves every register unchanged, whatever is on wr_reg and wr_data.
//   - x0: a write to index 0 is silently dropped; no storage is required for x0.
//   - Read: rd_data_N = (rd_reg_N==0) ? 0 : reg[rd_reg_N], purely combinational.
//     Reads have zero-cycle latency and settle within the same cycle as the address change.
//   - Same-cycle read/write of one register (default build): the read returns the OLD value.
//     The new value is visible only after the capturing clock edge; no forwarding.
//   - Both read ports may address the same register, or equal wr_reg, simultaneously.
//     Each port is independent and both return identical data.
//   - No handshake, no stall, no X-propagation: every index 0..31 is valid.
// CONFIGURATION
//   - Macro REG_FILE_WRITE_BYPASS_EN:
//     - Defined: a read port whose index equals wr_reg, while wr_en=1 and wr_reg!=0,
//       returns wr_data combinationally in the same cycle (write-to-read forwarding).
//       A read of x0 still returns 0.
//     - Undefined (default): no forwarding; same-cycle reads return the old value, as above.
// STRUCTURE
//   - Shared package riscv_32i_defs_pkg holds the definitions used here:
//     - word_t (logic [31:0]) and reg_addr_t (logic [4:0]);
//     - enum reg_name_t X0..X31, with X0 = 5'd0;
//     - constants XLEN=32 and NUM_REGS=32.
//   - One sub-module, reg_file_read_port: the index-to-data mux with the x0 zero check
//     and the optional bypass. It is instantiated twice, once per read port.
//   - The storage array and write logic live in the top module.
// TESTING
//   1. Reset then read: assert rst_n=0, release it, read every index on both ports
//      -> all rd_data = 32'h0.
//   2. Write x0: wr_en=1, wr_reg=0, wr_data=32'hFFFF_FFFF, clock once, read rd_reg_1=0
//      -> rd_data_1 = 32'h0.
//   3. Write then read: write x5=32'hDEAD_BEEF and x31=32'h1234_5678, then read rd_reg_1=5,
//      rd_reg_2=31 -> 32'hDEAD_BEEF and 32'h1234_5678.
//   4. wr_en=0 hold: x7=32'hA5A5_A5A5, then present wr_en=0, wr_reg=7, wr_data=32'h0
//      and clock -> x7 still reads 32'hA5A5_A5A5.
//   5. Same-cycle RAW: x3=32'h1, then present wr_en=1, wr_reg=3, wr_data=32'h2, rd_reg_1=3.
//      - Before the edge: rd_data_1 = 32'h1 (32'h2 with bypass enabled).
//      - After the edge: rd_data_1 = 32'h2.
//   6. Random: 1000 random transactions scored against a reference model, with
//      coverage of every wr_reg/rd_reg value and of wr_en x (wr_reg==rd_reg) crosses.

Source files
------------

// File: rtl/riscv_32i_defs_pkg.sv
// Shared RV32I definitions: word/index types, architectural register names and sizes.
// Used by riscv_reg_file and its read-port sub-module.
package riscv_32i_defs_pkg;

   localparam int XLEN     = 32;
   localparam int NUM_REGS = 32;

   typedef logic [XLEN-1:0] word_t;
   typedef logic [4:0]      reg_addr_t;

   typedef enum logic [4:0] {
      X0 = 5'd0, X1,  X2,  X3,  X4,  X5,  X6,  X7,
      X8,        X9,  X10, X11, X12, X13, X14, X15,
      X16,       X17, X18, X19, X20, X21, X22, X23,
      X24,       X25, X26, X27, X28, X29, X30, X31
   } reg_name_t;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port of the integer register file: index mux, x0 forced to zero.
// With REG_FILE_WRITE_BYPASS_EN defined, an in-flight write to the same index is forwarded.
module reg_file_read_port
   import riscv_32i_defs_pkg::*;
#(
   parameter int DATA_WIDTH = XLEN,
   parameter int NUM_REGS   = riscv_32i_defs_pkg::NUM_REGS,
   parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
   input  logic [ADDR_WIDTH-1:0] rd_reg,
   input  logic [DATA_WIDTH-1:0] regs [NUM_REGS],
`ifdef REG_FILE_WRITE_BYPASS_EN
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_reg,
   input  logic [DATA_WIDTH-1:0] wr_data,
`endif
   output logic [DATA_WIDTH-1:0] rd_data
);

   always_comb begin
      rd_data = regs[rd_reg];
`ifdef REG_FILE_WRITE_BYPASS_EN
      if (wr_en && (wr_reg != '0) && (wr_reg == rd_reg)) begin
         rd_data = wr_data;
      end
`endif
      // x0 check last so it overrides both storage and forwarding
      if (rd_reg == ADDR_WIDTH'(X0)) begin
         rd_data = '0;
      end
   end

endmodule

// File: rtl/riscv_reg_file.sv
// RV32I register file: 31 stored registers (x0 hardwired to zero), two async read ports,
// one synchronous write port. Optional write-to-read forwarding: REG_FILE_WRITE_BYPASS_EN.
module riscv_reg_file
   import riscv_32i_defs_pkg::*;
#(
   parameter int DATA_WIDTH = XLEN,
   parameter int NUM_REGS   = riscv_32i_defs_pkg::NUM_REGS,
   parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_reg,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_reg_1,
   input  logic [ADDR_WIDTH-1:0] rd_reg_2,
   output logic [DATA_WIDTH-1:0] rd_data_1,
   output logic [DATA_WIDTH-1:0] rd_data_2
);

   // No storage for x0; index 0 of the read view is a constant zero
   logic [DATA_WIDTH-1:0] regs_reg [1:NUM_REGS-1];
   logic [DATA_WIDTH-1:0] rd_view  [NUM_REGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (wr_en && (wr_reg != '0)) begin
         regs_reg[wr_reg] <= wr_data;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_view
         if (gi == 0) begin : g_zero
            assign rd_view[gi] = '0;
         end else begin : g_reg
            assign rd_view[gi] = regs_reg[gi];
         end
      end
   endgenerate

   reg_file_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_rd_port_1 (
      .rd_reg  (rd_reg_1),
      .regs    (rd_view),
`ifdef REG_FILE_WRITE_BYPASS_EN
      .wr_en   (wr_en),
      .wr_reg  (wr_reg),
      .wr_data (wr_data),
`endif
      .rd_data (rd_data_1)
   );

   reg_file_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_rd_port_2 (
      .rd_reg  (rd_reg_2),
      .regs    (rd_view),
`ifdef REG_FILE_WRITE_BYPASS_EN
      .wr_en   (wr_en),
      .wr_reg  (wr_reg),
      .wr_data (wr_data),
`endif
      .rd_data (rd_data_2)
   );

endmodule

// File: tb/tb_riscv_reg_file.sv
// Self-checking bench for riscv_reg_file: directed vector table, async-reset and RAW sequences,
// then random traffic scored against a reference array through an expectation queue.
module tb_riscv_reg_file;
   import riscv_32i_defs_pkg::*;

`ifdef REG_FILE_WRITE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_reg = '0;
   logic [31:0] wr_data = '0;
   logic [4:0]  rd_reg_1 = '0;
   logic [4:0]  rd_reg_2 = '0;
   logic [31:0] rd_data_1;
   logic [31:0] rd_data_2;

   always #5 clk = ~clk;

   riscv_reg_file dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_reg    (wr_reg),
      .wr_data   (wr_data),
      .rd_reg_1  (rd_reg_1),
      .rd_reg_2  (rd_reg_2),
      .rd_data_1 (rd_data_1),
      .rd_data_2 (rd_data_2)
   );

   typedef struct {
      logic        we;
      logic [4:0]  wr;
      logic [31:0] d;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] e1;
      logic [31:0] e2;
   } exp_t;

   exp_t        sb[$];
   vec_t        tbl[9];
   logic [31:0] model[32];
   int          passed = 0;
   int          total = 0;
   int          cov_wr[32];
   int          cov_rd[32];
   int          cov_x[2][2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Expected pre-edge read value from the reference array and the currently driven write
   function automatic logic [31:0] mexp(input logic [4:0] r);
      if (r == 5'd0) return 32'h0;
      if (BYP && wr_en && (wr_reg != 5'd0) && (wr_reg == r)) return wr_data;
      return model[r];
   endfunction

   task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] d,
                        input logic [4:0] r1, input logic [4:0] r2);
      wr_en = we; wr_reg = wr; wr_data = d; rd_reg_1 = r1; rd_reg_2 = r2;
   endtask

   // Inputs already driven just after a posedge; compare at negedge, commit at next posedge
   task automatic cycle(input string name, input logic [31:0] e1, input logic [31:0] e2);
      exp_t e;
      sb.push_back('{name, e1, e2});
      @(negedge clk);
      e = sb.pop_front();
      check({e.name, "_rd1"}, rd_data_1, e.e1);
      check({e.name, "_rd2"}, rd_data_2, e.e2);
      $display("[%0t] %s we=%0b wr=%0d d=%h | rd1[%0d]=%h rd2[%0d]=%h",
               $time, e.name, wr_en, wr_reg, wr_data, rd_reg_1, rd_data_1, rd_reg_2, rd_data_2);
      @(posedge clk);
      if (rst_n && wr_en && (wr_reg != 5'd0)) model[wr_reg] = wr_data;
      #1;
   endtask

   initial begin
      logic        we;
      logic [4:0]  wr, r1, r2;
      logic [31:0] d;
      int          nwr, nrd, nx;

      tbl[0] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0,         32'h0};
      tbl[1] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd1,  32'h0,         32'h0};
      tbl[2] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd1,  5'd2,  32'h0,         32'h0};
      tbl[3] = '{1'b1, 5'd31, 32'h1234_5678, 5'd5,  5'd0,  32'hDEAD_BEEF, 32'h0};
      tbl[4] = '{1'b1, 5'd7,  32'hA5A5_A5A5, 5'd5,  5'd31, 32'hDEAD_BEEF, 32'h1234_5678};
      tbl[5] = '{1'b0, 5'd7,  32'h0,         5'd7,  5'd7,  32'hA5A5_A5A5, 32'hA5A5_A5A5};
      tbl[6] = '{1'b0, 5'd0,  32'hFFFF_FFFF, 5'd7,  5'd0,  32'hA5A5_A5A5, 32'h0};
      tbl[7] = '{1'b1, 5'd3,  32'h1,         5'd31, 5'd5,  32'h1234_5678, 32'hDEAD_BEEF};
      tbl[8] = '{1'b0, 5'd3,  32'h0,         5'd7,  5'd3,  32'hA5A5_A5A5, 32'h1};
      for (int i = 0; i < 32; i++) begin
         model[i] = 32'h0; cov_wr[i] = 0; cov_rd[i] = 0;
      end
      for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) cov_x[i][j] = 0;

      // Reset held: outputs combinationally zero
      drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd31);
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold_rd1", rd_data_1, 32'h0);
      check("reset_hold_rd2", rd_data_2, 32'h0);
      rst_n = 1'b1;

      // Every index on both ports reads zero after reset (wr_en=0 with junk on the write bus)
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 5'(i), 32'hFFFF_FFFF, 5'(i), 5'(31 - i));
         cycle("rst_rd", 32'h0, 32'h0);
      end

      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].we, tbl[i].wr, tbl[i].d, tbl[i].r1, tbl[i].r2);
         cycle($sformatf("vec%0d", i), tbl[i].e1, tbl[i].e2);
      end

      // Same-cycle read/write of x3 (holds 1)
      drive(1'b1, 5'd3, 32'h2, 5'd3, 5'd3);
      cycle("raw_pre", BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1);
      drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
      cycle("raw_post", 32'h2, 32'h2);

      // Asynchronous reset mid-cycle, with a write attempted across an edge while in reset
      drive(1'b1, 5'd5, 32'h5555_0000, 5'd31, 5'd7);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_rd1", rd_data_1, 32'h0);
      check("arst_rd2", rd_data_2, 32'h0);
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_reg_1 = 5'd5;
      rd_reg_2 = 5'd3;
      #1;
      check("arst_wr_ignored", rd_data_1, 32'h0);
      #2;
      rst_n = 1'b1;
      #1;
      check("arst_rel_rd1", rd_data_1, 32'h0);
      check("arst_rel_rd2", rd_data_2, 32'h0);
      @(posedge clk);
      #1;

      // Random traffic against the reference array
      for (int n = 0; n < 1000; n++) begin
         we = 1'($urandom_range(0, 1));
         wr = 5'($urandom_range(0, 31));
         d  = $urandom;
         r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
         r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
         if (n < 32) begin
            wr = 5'(n); r1 = 5'(31 - n); r2 = 5'(n);
         end
         drive(we, wr, d, r1, r2);
         cov_wr[wr]++; cov_rd[r1]++; cov_rd[r2]++;
         cov_x[we][wr == r1]++;
         cycle("rnd", mexp(r1), mexp(r2));
      end

      nwr = 0; nrd = 0; nx = 0;
      for (int i = 0; i < 32; i++) begin
         if (cov_wr[i] > 0) nwr++;
         if (cov_rd[i] > 0) nrd++;
      end
      for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) if (cov_x[i][j] > 0) nx++;
      $display("coverage: wr_reg %0d/32 rd_reg %0d/32 wr_en x same-index %0d/4", nwr, nrd, nx);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
